// File: rtl/node_path_encoder.sv
// node_path_encoder
// Walks parent links from a target node up to the root through a shared tree
// table, stacks the field ids met on the way, then streams them root-first
// under valid/ready. Each tree level costs one FETCH and one WAIT cycle.
// Optional build macro: NODE_PATH_OVF_CHECK_EN -- when defined, a path longer
// than MAX_DEPTH is reported on err and dropped; otherwise the collected
// (root-side truncated) ids are emitted as a normal path.

module node_path_encoder #(
    parameter int                ADDR_W    = 8,
    parameter int                FIELD_W   = 8,
    parameter int                MAX_DEPTH = 8,
    parameter logic [ADDR_W-1:0] ROOT_ADDR = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic               req_valid,
    output logic               req_ready,
    output logic               lookup_rd,
    output logic [ADDR_W-1:0]  lookup_addr,
    input  logic [ADDR_W-1:0]  lookup_parent,
    input  logic [FIELD_W-1:0] lookup_field_id,
    output logic [FIELD_W-1:0] out_field_id,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               done,
    output logic               err
);

    localparam int               CNT_W      = $clog2(MAX_DEPTH + 1);
    localparam int               IDX_W      = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_FULL = CNT_W'(MAX_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_cur;
    logic [CNT_W-1:0]   r_depth;
    logic [FIELD_W-1:0] r_stack [MAX_DEPTH];
    logic               r_done;

    logic               w_accept;
    logic               w_root_req;
    logic               w_push;
    logic               w_pop;
    logic               w_finish;
    logic               w_can_push;
    logic               w_full_after;
    logic               w_emit;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_top_idx;
`ifdef NODE_PATH_OVF_CHECK_EN
    logic               w_ovf;
    logic               r_err;
`endif

    // The counter saturates at MAX_DEPTH; the walk always leaves WAIT once full.
    assign w_can_push   = (r_depth != DEPTH_FULL);
    assign w_full_after = ((r_depth + DEPTH_ONE) == DEPTH_FULL);
    assign w_wr_idx     = IDX_W'(r_depth);
    assign w_top_idx    = IDX_W'(r_depth - DEPTH_ONE);

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle control strobes.
    // NOTE: every signal gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_root_req   = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_finish     = 1'b0;
`ifdef NODE_PATH_OVF_CHECK_EN
        w_ovf        = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (req_addr == ROOT_ADDR) begin
                        w_root_req = 1'b1;
                    end else begin
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                w_push = w_can_push;
                if (lookup_parent == ROOT_ADDR) begin
                    w_state_next = S_EMIT;
                end else if (w_full_after) begin
`ifdef NODE_PATH_OVF_CHECK_EN
                    w_ovf        = 1'b1;
                    w_state_next = S_IDLE;
`else
                    w_state_next = S_EMIT;
`endif
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_pop = 1'b1;
                    if (r_depth == DEPTH_ONE) begin
                        w_finish     = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Walk pointer, stack depth and the done pulse.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_cur   <= '0;
            r_depth <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_root_req | w_finish;
            if (w_accept) begin
                r_cur   <= req_addr;
                r_depth <= '0;
            end else if (w_push) begin
                r_cur   <= lookup_parent;
                r_depth <= r_depth + DEPTH_ONE;
            end else if (w_pop) begin
                r_depth <= r_depth - DEPTH_ONE;
            end
        end
    end

    // Stack storage, written on each WAIT.
    // NOTE: the storage array is deliberately not reset; only r_depth
    // qualifies which entries are live, so resetting the data buys nothing.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_stack[w_wr_idx] <= lookup_field_id;
        end
    end

`ifdef NODE_PATH_OVF_CHECK_EN
    // Overflow pulse lands in the cycle after the WAIT that filled the stack.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_ovf;
        end
    end

    assign err = reset_i & r_err;
`else
    assign err = 1'b0;
`endif

    // Outputs decode from registered state and are forced low while reset is held.
    assign w_emit       = reset_i & (r_state == S_EMIT);
    assign req_ready    = reset_i & (r_state == S_IDLE);
    assign lookup_rd    = reset_i & (r_state == S_FETCH);
    assign lookup_addr  = lookup_rd ? r_cur : '0;
    assign out_valid    = w_emit;
    assign out_field_id = w_emit ? r_stack[w_top_idx] : '0;
    assign out_last     = w_emit & (r_depth == DEPTH_ONE);
    assign done         = reset_i & r_done;

endmodule

// File: tb/tb_node_path_encoder.sv
// Self-checking bench for node_path_encoder: a path-level reference model
// predicts every output each cycle, and directed tests pin exact cycles and
// values. Works with and without NODE_PATH_OVF_CHECK_EN.

module tb_node_path_encoder;

    localparam int ADDR_W    = 8;
    localparam int FIELD_W   = 8;
    localparam int MAX_DEPTH = 8;

    logic               clk_i = 1'b0;
    logic               reset_i;
    logic [ADDR_W-1:0]  req_addr;
    logic               req_valid;
    logic               req_ready;
    logic               lookup_rd;
    logic [ADDR_W-1:0]  lookup_addr;
    logic [ADDR_W-1:0]  lookup_parent;
    logic [FIELD_W-1:0] lookup_field_id;
    logic [FIELD_W-1:0] out_field_id;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               done;
    logic               err;

    node_path_encoder #(
        .ADDR_W   (ADDR_W),
        .FIELD_W  (FIELD_W),
        .MAX_DEPTH(MAX_DEPTH),
        .ROOT_ADDR(8'd0)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req_addr       (req_addr),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .lookup_rd      (lookup_rd),
        .lookup_addr    (lookup_addr),
        .lookup_parent  (lookup_parent),
        .lookup_field_id(lookup_field_id),
        .out_field_id   (out_field_id),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .done           (done),
        .err            (err)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Tree table, answered one cycle after each read strobe.
    logic [ADDR_W-1:0]  tbl_parent [256];
    logic [FIELD_W-1:0] tbl_field  [256];

    always @(posedge clk_i) begin
        if (lookup_rd) begin
            lookup_parent   <= tbl_parent[lookup_addr];
            lookup_field_id <= tbl_field[lookup_addr];
        end else begin
            lookup_parent   <= 8'hEE;
            lookup_field_id <= 8'hEE;
        end
    end

    // Reference model: per request, the walked address list and the beat list.
    typedef enum {P_IDLE, P_WALK, P_EMIT} phase_t;
    phase_t             m_phase   = P_IDLE;
    int                 m_n       = 0;
    int                 m_done_at = -1;
    int                 m_err_at  = -1;
    bit                 m_ovf     = 1'b0;
    logic [ADDR_W-1:0]  m_walk[$];
    logic [FIELD_W-1:0] m_beats[$];

    // Observation logs used by the directed tests.
    int                 acc_log[$];
    int                 done_log[$];
    int                 err_log[$];
    int                 beat_cyc[$];
    logic [ADDR_W-1:0]  lk_log[$];
    logic [FIELD_W-1:0] beat_val[$];
    bit                 beat_last[$];

    task automatic plan(input logic [ADDR_W-1:0] target);
        logic [ADDR_W-1:0] a;
        m_walk.delete();
        m_beats.delete();
        a = target;
        while (a != 8'd0 && m_walk.size() < MAX_DEPTH) begin
            m_walk.push_back(a);
            m_beats.push_front(tbl_field[a]);
            a = tbl_parent[a];
        end
`ifdef NODE_PATH_OVF_CHECK_EN
        m_ovf = (a != 8'd0);
`else
        m_ovf = 1'b0;
`endif
    endtask

    // Compare process: checks every output every cycle against the model.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_lookup_rd", lookup_rd, 0);
            check("rst_lookup_addr", lookup_addr, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_field_id", out_field_id, 0);
            check("rst_out_last", out_last, 0);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            m_phase   = P_IDLE;
            m_done_at = -1;
            m_err_at  = -1;
        end else begin
            check("req_ready", req_ready, m_phase == P_IDLE);
            check("lookup_rd", lookup_rd, (m_phase == P_WALK) && (((cyc - m_n) % 2) == 1));
            if (m_phase == P_WALK && ((cyc - m_n) % 2) == 1)
                check("lookup_addr", lookup_addr, m_walk[(cyc - m_n - 1) / 2]);
            check("out_valid", out_valid, m_phase == P_EMIT);
            if (m_phase == P_EMIT) begin
                check("out_field_id", out_field_id, m_beats[0]);
                check("out_last", out_last, m_beats.size() == 1);
            end
            check("done", done, cyc == m_done_at);
            check("err", err, cyc == m_err_at);

            if (lookup_rd) lk_log.push_back(lookup_addr);
            if (out_valid && out_ready) begin
                beat_val.push_back(out_field_id);
                beat_last.push_back(out_last);
                beat_cyc.push_back(cyc);
            end
            if (done) done_log.push_back(cyc);
            if (err) err_log.push_back(cyc);

            case (m_phase)
                P_IDLE: begin
                    if (req_valid) begin
                        acc_log.push_back(cyc);
                        plan(req_addr);
                        if (m_walk.size() == 0) begin
                            m_done_at = cyc + 1;
                        end else begin
                            m_n     = cyc;
                            m_phase = P_WALK;
                        end
                    end
                end
                P_WALK: begin
                    if (cyc == m_n + 2 * m_walk.size()) begin
                        if (m_ovf) begin
                            m_err_at = cyc + 1;
                            m_phase  = P_IDLE;
                        end else begin
                            m_phase = P_EMIT;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        void'(m_beats.pop_front());
                        if (m_beats.size() == 0) begin
                            m_done_at = cyc + 1;
                            m_phase   = P_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    task automatic clear_logs();
        acc_log.delete();
        done_log.delete();
        err_log.delete();
        beat_cyc.delete();
        lk_log.delete();
        beat_val.delete();
        beat_last.delete();
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_logs(input int nd, input int ne, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_log.size() >= nd && err_log.size() >= ne) break;
            step();
        end
    endtask

    task automatic wait_cycle(input int target);
        for (int i = 0; i < 200; i++) begin
            if (cyc >= target) break;
            step();
        end
    endtask

    task automatic send(input logic [ADDR_W-1:0] a);
        req_addr  = a;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    int n0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            tbl_parent[i] = 8'd0;
            tbl_field[i]  = 8'd0;
        end
        tbl_parent[1] = 8'd0; tbl_field[1] = 8'd5;
        tbl_parent[2] = 8'd1; tbl_field[2] = 8'd7;
        tbl_parent[3] = 8'd2; tbl_field[3] = 8'd9;
        tbl_parent[4] = 8'd4; tbl_field[4] = 8'd3;

        reset_i   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b1;
        step();

        // Depth-3 path, no backpressure.
        clear_logs();
        send(8'd3);
        wait_logs(1, 0, 40);
        n0 = acc_log[0];
        check("t1_done_count", done_log.size(), 1);
        check("t1_beat_count", beat_val.size(), 3);
        if (beat_val.size() == 3) begin
            check("t1_beat0", beat_val[0], 5);
            check("t1_beat1", beat_val[1], 7);
            check("t1_beat2", beat_val[2], 9);
            check("t1_beat0_cyc", beat_cyc[0], n0 + 7);
            check("t1_beat2_cyc", beat_cyc[2], n0 + 9);
            check("t1_last_on_9", beat_last[2], 1);
            check("t1_not_last_5", beat_last[0], 0);
        end
        if (done_log.size() == 1) check("t1_done_cyc", done_log[0], n0 + 10);
        check("t1_lookup_count", lk_log.size(), 3);
        if (lk_log.size() == 3) begin
            check("t1_lookup0", lk_log[0], 3);
            check("t1_lookup1", lk_log[1], 2);
            check("t1_lookup2", lk_log[2], 1);
        end
        step(); step();

        // Root request.
        clear_logs();
        send(8'd0);
        wait_logs(1, 0, 10);
        n0 = acc_log[0];
        check("t2_done_count", done_log.size(), 1);
        if (done_log.size() == 1) check("t2_done_cyc", done_log[0], n0 + 1);
        check("t2_no_lookup", lk_log.size(), 0);
        check("t2_no_beats", beat_val.size(), 0);
        step(); step();

        // Backpressure while beat 7 is presented.
        clear_logs();
        send(8'd3);
        n0 = acc_log[0];
        wait_cycle(n0 + 8);
        out_ready = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 out_ready = 1'b1;
        wait_logs(1, 0, 40);
        check("t3_beat_count", beat_val.size(), 3);
        if (beat_val.size() == 3) begin
            check("t3_beat1", beat_val[1], 7);
            check("t3_beat1_cyc", beat_cyc[1], n0 + 11);
            check("t3_beat2", beat_val[2], 9);
            check("t3_beat2_cyc", beat_cyc[2], n0 + 12);
        end
        if (done_log.size() == 1) check("t3_done_cyc", done_log[0], n0 + 13);
        step(); step();

        // Self-loop node: path never reaches the root.
        clear_logs();
        send(8'd4);
        n0 = acc_log[0];
`ifdef NODE_PATH_OVF_CHECK_EN
        wait_logs(0, 1, 60);
        check("t4_err_count", err_log.size(), 1);
        if (err_log.size() == 1) check("t4_err_cyc", err_log[0], n0 + 17);
        step(); step();
        check("t4_no_beats", beat_val.size(), 0);
        check("t4_no_done", done_log.size(), 0);
`else
        wait_logs(1, 0, 60);
        check("t4_beat_count", beat_val.size(), 8);
        if (beat_val.size() == 8) begin
            for (int i = 0; i < 8; i++) check("t4_beat_val", beat_val[i], 3);
            check("t4_first_cyc", beat_cyc[0], n0 + 17);
            check("t4_last_flag", beat_last[7], 1);
            check("t4_first_not_last", beat_last[0], 0);
        end
        if (done_log.size() == 1) check("t4_done_cyc", done_log[0], n0 + 25);
        check("t4_no_err", err_log.size(), 0);
`endif
        step(); step();

        // Reset during EMIT aborts silently.
        clear_logs();
        send(8'd3);
        n0 = acc_log[0];
        wait_cycle(n0 + 8);
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        #1;
        check("t5_ready_after_reset", req_ready, 1);
        repeat (10) step();
        check("t5_no_done", done_log.size(), 0);
        check("t5_no_err", err_log.size(), 0);
        check("t5_one_beat", beat_val.size(), 1);

        // req_valid held high across two requests.
        clear_logs();
        req_addr  = 8'd2;
        req_valid = 1'b1;
        step();
        req_addr = 8'd1;
        for (int i = 0; i < 40; i++) begin
            if (acc_log.size() >= 2) break;
            step();
        end
        step();
        req_valid = 1'b0;
        wait_logs(2, 0, 40);
        check("t6_accept_count", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            n0 = acc_log[0];
            check("t6_second_accept", acc_log[1], n0 + 7);
        end
        check("t6_beat_count", beat_val.size(), 3);
        if (beat_val.size() == 3) begin
            check("t6_beat0", beat_val[0], 5);
            check("t6_beat1", beat_val[1], 7);
            check("t6_beat2", beat_val[2], 5);
        end
        check("t6_done_count", done_log.size(), 2);
        if (done_log.size() == 2) begin
            check("t6_done0", done_log[0], n0 + 7);
            check("t6_done1", done_log[1], n0 + 11);
        end
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
